// File: rtl/spram_block_sink_if.sv
// spram_block_sink_if: stream input and SPRAM write port bundle.
// The upstream/memory side uses master, the sink uses slave.
interface spram_block_sink_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14
);
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic [ADDR_WIDTH-1:0] spram_addr;
   logic [DATA_WIDTH-1:0] spram_wdata;
   logic                  spram_we;

   modport master (
      output s_axis_tdata,
      output s_axis_tvalid,
      input  s_axis_tready,
      input  spram_addr,
      input  spram_wdata,
      input  spram_we
   );

   modport slave (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      output s_axis_tready,
      output spram_addr,
      output spram_wdata,
      output spram_we
   );
endinterface

// File: rtl/spram_block_sink.sv
// spram_block_sink: captures one fixed-length stream block into SPRAM.
// Upstream never stalls; beats seen while not ready are counted as drops.
module spram_block_sink #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 14,
   parameter int BLOCK_WORDS    = 1024,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  resetn,
   spram_block_sink_if.slave     io_bus,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_timeout_err,
   output logic [7:0]            o_drop_count
);
   localparam int IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(BLOCK_WORDS - 1);
   localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_FILL,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic                  r_terr;
   logic [IW-1:0]         r_idx;
   logic [GW-1:0]         r_gap;
   logic [7:0]            r_drops;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_expire;
   logic                  w_arm;
   logic                  w_drop;

   // Handshake qualifiers and next-state selection; abort beats any beat.
   always_comb begin
      w_ready     = (r_state == S_ARMED) || (r_state == S_FILL);
      w_accept    = w_ready && io_bus.s_axis_tvalid && !i_abort;
      w_last      = w_accept && (r_idx == LAST_IDX);
      w_expire    = (r_state == S_FILL) && !w_accept && !i_abort
                    && (r_gap == GAP_LIMIT);
      w_arm       = (r_state == S_IDLE) && i_start;
      w_drop      = io_bus.s_axis_tvalid && !w_ready;
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_start)
               w_state_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (i_abort)
               w_state_nxt = S_IDLE;
            else if (w_last)
               w_state_nxt = S_DONE;
            else if (w_accept)
               w_state_nxt = S_FILL;
         end
         S_FILL: begin
            if (i_abort)
               w_state_nxt = S_IDLE;
            else if (w_last)
               w_state_nxt = S_DONE;
            else if (w_expire)
               w_state_nxt = S_IDLE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // SPRAM write port: one registered write per accepted beat.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_accept;
         if (w_accept) begin
            r_addr  <= r_base + ADDR_WIDTH'(r_idx);
            r_wdata <= io_bus.s_axis_tdata;
         end
      end
   end

   // Block base, word index, inter-beat gap counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_base <= '0;
         r_idx  <= '0;
         r_gap  <= '0;
         r_terr <= 1'b0;
      end else begin
         if (w_arm) begin
            r_base <= i_base_addr;
            r_idx  <= '0;
            r_gap  <= '0;
            r_terr <= 1'b0;
         end else if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + IW'(1);
            r_gap <= '0;
         end else if (w_expire) begin
            r_gap  <= '0;
            r_terr <= 1'b1;
         end else if (r_state == S_FILL) begin
            r_gap <= r_gap + GW'(1);
         end
      end
   end

   // Saturating count of beats offered while not ready.
   always_ff @(posedge clk) begin
      if (!resetn)
         r_drops <= '0;
      else if (w_drop && (r_drops != 8'hFF))
         r_drops <= r_drops + 8'd1;
   end

   assign io_bus.s_axis_tready = w_ready;
   assign io_bus.spram_addr    = r_addr;
   assign io_bus.spram_wdata   = r_wdata;
   assign io_bus.spram_we      = r_we;
   assign o_busy               = w_ready;
   assign o_done               = (r_state == S_DONE);
   assign o_timeout_err        = r_terr;
   assign o_drop_count         = r_drops;
endmodule
